// File: rtl/hs32_mem_arbiter_if.sv
// Bus bundle for hs32_mem_arbiter: fetch port, execute port and the shared memory port.
// "slave" is the arbiter's view; "master" is the view of whatever drives requests and memory.
interface hs32_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          reqf;
    logic [AW-1:0] addrf;
    logic          ackf;
    logic [DW-1:0] dtrf;

    logic          reqe;
    logic [AW-1:0] addre;
    logic          rwe;
    logic [DW-1:0] dtwe;
    logic          acke;
    logic [DW-1:0] dtre;

    logic [AW-1:0] addr;
    logic          rw;
    logic [DW-1:0] dtw;
    logic [DW-1:0] dtr;
    logic          valid;
    logic          ready;

    modport slave (
        input  reqf, addrf, reqe, addre, rwe, dtwe, dtr, ready,
        output ackf, dtrf, acke, dtre, addr, rw, dtw, valid
    );

    modport master (
        output reqf, addrf, reqe, addre, rwe, dtwe, dtr, ready,
        input  ackf, dtrf, acke, dtre, addr, rw, dtw, valid
    );
endinterface

// File: rtl/hs32_mem_arbiter.sv
// Two-requester (fetch/execute) arbiter onto one memory port, one transaction in flight.
// Define HS32_ARB_FAIR_EN for round-robin between simultaneous requests; default is execute priority.
module hs32_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    hs32_mem_arbiter_if.slave     bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSYF = 2'd1;
    localparam logic [1:0] S_BUSYE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          pendf_q, pendf_d;
    logic          pende_q, pende_d;
    logic [AW-1:0] f_addr_q, f_addr_d;
    logic [AW-1:0] e_addr_q, e_addr_d;
    logic          e_rw_q, e_rw_d;
    logic [DW-1:0] e_dtw_q, e_dtw_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rw_q, rw_d;
    logic [DW-1:0] dtw_q, dtw_d;
    logic          ackf_q, ackf_d;
    logic          acke_q, acke_d;
    logic [DW-1:0] dtrf_q, dtrf_d;
    logic [DW-1:0] dtre_q, dtre_d;
    logic          e_wins;
    logic          grant_e;

`ifdef HS32_ARB_FAIR_EN
    logic          last_e_q, last_e_d;
    assign e_wins = ~last_e_q;
`else
    assign e_wins = 1'b1;
`endif

    // Grant decisions look only at registered pending flags, giving req->valid latency of two cycles.
    assign grant_e = pende_q & (~pendf_q | e_wins);

    always_comb begin
        state_d  = state_q;
        pendf_d  = pendf_q;
        pende_d  = pende_q;
        f_addr_d = f_addr_q;
        e_addr_d = e_addr_q;
        e_rw_d   = e_rw_q;
        e_dtw_d  = e_dtw_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        dtw_d    = dtw_q;
        ackf_d   = 1'b0;
        acke_d   = 1'b0;
        dtrf_d   = dtrf_q;
        dtre_d   = dtre_q;
`ifdef HS32_ARB_FAIR_EN
        last_e_d = last_e_q;
`endif

        if (bus.reqf && !pendf_q) begin
            pendf_d  = 1'b1;
            f_addr_d = bus.addrf;
        end
        if (bus.reqe && !pende_q) begin
            pende_d  = 1'b1;
            e_addr_d = bus.addre;
            e_rw_d   = bus.rwe;
            e_dtw_d  = bus.dtwe;
        end

        case (state_q)
            S_IDLE: begin
                if (grant_e) begin
                    state_d  = S_BUSYE;
                    valid_d  = 1'b1;
                    addr_d   = e_addr_q;
                    rw_d     = e_rw_q;
                    dtw_d    = e_dtw_q;
`ifdef HS32_ARB_FAIR_EN
                    last_e_d = 1'b1;
`endif
                end else if (pendf_q) begin
                    state_d  = S_BUSYF;
                    valid_d  = 1'b1;
                    addr_d   = f_addr_q;
                    rw_d     = 1'b0;
                    dtw_d    = '0;
`ifdef HS32_ARB_FAIR_EN
                    last_e_d = 1'b0;
`endif
                end
            end
            S_BUSYF: begin
                if (bus.ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    addr_d  = '0;
                    rw_d    = 1'b0;
                    dtw_d   = '0;
                    pendf_d = 1'b0;
                    ackf_d  = 1'b1;
                    dtrf_d  = bus.dtr;
                end
            end
            S_BUSYE: begin
                if (bus.ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    addr_d  = '0;
                    rw_d    = 1'b0;
                    dtw_d   = '0;
                    pende_d = 1'b0;
                    acke_d  = 1'b1;
                    dtre_d  = bus.dtr;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                addr_d  = '0;
                rw_d    = 1'b0;
                dtw_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pendf_q  <= 1'b0;
            pende_q  <= 1'b0;
            f_addr_q <= '0;
            e_addr_q <= '0;
            e_rw_q   <= 1'b0;
            e_dtw_q  <= '0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            dtw_q    <= '0;
            ackf_q   <= 1'b0;
            acke_q   <= 1'b0;
            dtrf_q   <= '0;
            dtre_q   <= '0;
`ifdef HS32_ARB_FAIR_EN
            last_e_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pendf_q  <= pendf_d;
            pende_q  <= pende_d;
            f_addr_q <= f_addr_d;
            e_addr_q <= e_addr_d;
            e_rw_q   <= e_rw_d;
            e_dtw_q  <= e_dtw_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            dtw_q    <= dtw_d;
            ackf_q   <= ackf_d;
            acke_q   <= acke_d;
            dtrf_q   <= dtrf_d;
            dtre_q   <= dtre_d;
`ifdef HS32_ARB_FAIR_EN
            last_e_q <= last_e_d;
`endif
        end
    end

    assign bus.valid = valid_q;
    assign bus.addr  = addr_q;
    assign bus.rw    = rw_q;
    assign bus.dtw   = dtw_q;
    assign bus.ackf  = ackf_q;
    assign bus.acke  = acke_q;
    assign bus.dtrf  = dtrf_q;
    assign bus.dtre  = dtre_q;
endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// Directed scoreboard bench for hs32_mem_arbiter: expected memory transactions are queued when
// requests are driven and popped when the arbiter raises valid; inputs driven and outputs sampled on negedge.
module tb_hs32_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hs32_mem_arbiter_if #(.AW(32), .DW(32)) bus ();
    hs32_mem_arbiter #(.AW(32), .DW(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic        is_e;
        logic [31:0] addr;
        logic        rw;
        logic [31:0] dtw;
        logic [31:0] rdata;
    } txn_t;

    txn_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_e, input logic [31:0] a, input logic rw,
                        input logic [31:0] d, input logic [31:0] r);
        txn_t t;
        t.is_e = is_e; t.addr = a; t.rw = rw; t.dtw = is_e ? d : 32'h0; t.rdata = r;
        sb.push_back(t);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.valid === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) check("valid_timeout", {31'h0, bus.valid}, 32'h1);
    endtask

    // Serve the next memory transaction; optionally refill the fetch slot in the ack cycle.
    task automatic serve(input int delay, input bit refill, input logic [31:0] refill_addr,
                         input logic [31:0] refill_rdata);
        bit   ok;
        txn_t t;
        wait_valid(ok);
        if (!ok) return;
        if (sb.size() == 0) begin
            check("unexpected_valid", {31'h0, bus.valid}, 32'h0);
            return;
        end
        t = sb.pop_front();
        $display("txn %s addr=0x%08h rw=%0d dtw=0x%08h", t.is_e ? "E" : "F", bus.addr, bus.rw, bus.dtw);
        check("addr", bus.addr, t.addr);
        check("rw", {31'h0, bus.rw}, {31'h0, t.rw});
        check("dtw", bus.dtw, t.dtw);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("valid_held", {31'h0, bus.valid}, 32'h1);
        end
        bus.ready = 1'b1;
        bus.dtr   = t.rdata;
        @(negedge clk);
        bus.ready = 1'b0;
        bus.dtr   = $urandom;
        check("ackf_pulse", {31'h0, bus.ackf}, {31'h0, ~t.is_e});
        check("acke_pulse", {31'h0, bus.acke}, {31'h0, t.is_e});
        if (!t.is_e) check("dtrf", bus.dtrf, t.rdata);
        else if (!t.rw) check("dtre", bus.dtre, t.rdata);
        check("valid_drop", {31'h0, bus.valid}, 32'h0);
        check("addr_zero", bus.addr, 32'h0);
        if (refill) begin
            bus.reqf  = 1'b1;
            bus.addrf = refill_addr;
            push(1'b0, refill_addr, 1'b0, 32'h0, refill_rdata);
        end
        @(negedge clk);
        bus.reqf = 1'b0;
        check("ack_one_cycle", {30'h0, bus.ackf, bus.acke}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset = 1'b0;
        bus.reqf = 0; bus.addrf = 0; bus.reqe = 0; bus.addre = 0; bus.rwe = 0; bus.dtwe = 0;
        bus.dtr = 0; bus.ready = 0;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'h0, bus.valid}, 32'h0);
        check("rst_acks", {30'h0, bus.ackf, bus.acke}, 32'h0);
        check("rst_bus", bus.addr | bus.dtw | {31'h0, bus.rw}, 32'h0);
        check("rst_dtr", bus.dtrf | bus.dtre, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Fetch read, ready 3 cycles after valid, with exact req->valid latency.
        bus.reqf = 1'b1; bus.addrf = 32'h100;
        push(1'b0, 32'h100, 1'b0, 32'h0, 32'hDEADBEEF);
        @(negedge clk);
        bus.reqf = 1'b0;
        check("lat_n1", {31'h0, bus.valid}, 32'h0);
        @(negedge clk);
        check("lat_n2", {31'h0, bus.valid}, 32'h1);
        serve(3, 1'b1, 32'h180, 32'h0BADF00D);
        serve(0, 1'b0, 32'h0, 32'h0);

        // Execute write.
        bus.reqe = 1'b1; bus.addre = 32'h2000; bus.rwe = 1'b1; bus.dtwe = 32'h12345678;
        push(1'b1, 32'h2000, 1'b1, 32'h12345678, 32'h55AA55AA);
        @(negedge clk);
        bus.reqe = 1'b0; bus.rwe = 1'b0;
        serve(2, 1'b0, 32'h0, 32'h0);

        // Simultaneous requests; last grant was execute.
        bus.reqf = 1'b1; bus.addrf = 32'h400;
        bus.reqe = 1'b1; bus.addre = 32'h4000; bus.rwe = 1'b0; bus.dtwe = 32'h0;
`ifdef HS32_ARB_FAIR_EN
        push(1'b0, 32'h400, 1'b0, 32'h0, 32'h11111111);
        push(1'b1, 32'h4000, 1'b0, 32'h0, 32'h22222222);
`else
        push(1'b1, 32'h4000, 1'b0, 32'h0, 32'h22222222);
        push(1'b0, 32'h400, 1'b0, 32'h0, 32'h11111111);
`endif
        @(negedge clk);
        bus.reqf = 1'b0; bus.reqe = 1'b0;
        serve(0, 1'b0, 32'h0, 32'h0);
        serve(0, 1'b0, 32'h0, 32'h0);

        // Second fetch request while first is pending is dropped.
        bus.reqf = 1'b1; bus.addrf = 32'h100;
        push(1'b0, 32'h100, 1'b0, 32'h0, 32'h31415926);
        @(negedge clk);
        bus.addrf = 32'h200;
        @(negedge clk);
        bus.reqf = 1'b0;
        serve(1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("no_second_valid", {31'h0, bus.valid}, 32'h0);
            check("no_second_ackf", {31'h0, bus.ackf}, 32'h0);
            @(negedge clk);
        end

        // Stray ready while idle.
        bus.ready = 1'b1; bus.dtr = 32'hFFFFFFFF;
        @(negedge clk);
        bus.ready = 1'b0;
        check("idle_ready_acks", {30'h0, bus.ackf, bus.acke}, 32'h0);
        check("idle_ready_valid", {31'h0, bus.valid}, 32'h0);
        bus.reqe = 1'b1; bus.addre = 32'h3000; bus.rwe = 1'b0;
        push(1'b1, 32'h3000, 1'b0, 32'h0, 32'hCAFEF00D);
        @(negedge clk);
        bus.reqe = 1'b0;
        serve(0, 1'b0, 32'h0, 32'h0);

        // Reset during an in-flight transaction.
        bus.reqe = 1'b1; bus.addre = 32'h5000; bus.rwe = 1'b1; bus.dtwe = 32'hA5A5A5A5;
        @(negedge clk);
        bus.reqe = 1'b0; bus.rwe = 1'b0;
        wait_valid(ok);
        #1 reset = 1'b0;
        #1;
        $display("txn reset valid=%0d addr=0x%08h", bus.valid, bus.addr);
        check("rst_mid_valid", {31'h0, bus.valid}, 32'h0);
        check("rst_mid_bus", bus.addr | bus.dtw | {31'h0, bus.rw}, 32'h0);
        bus.reqf = 1'b1; bus.addrf = 32'h600;
        @(negedge clk);
        bus.reqf = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_valid", {31'h0, bus.valid}, 32'h0);
            check("post_rst_acks", {30'h0, bus.ackf, bus.acke}, 32'h0);
        end
        check("sb_drained", sb.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
